// File: rtl/led_sb_ctrl_gen.sv
// Memory-mapped LED controller with per-LED blink and optional global PWM brightness.
// Define LED_SB_PWM_EN to include the PWM_DUTY register and PWM counter.
module led_sb_ctrl_gen #(
  parameter int unsigned LED_W     = 16,
  parameter int unsigned BLINK_DIV = 10_000_000,
  parameter int unsigned PWM_W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             write_enable_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      write_data_i,
  output logic [31:0]      read_data_o,
  output logic [LED_W-1:0] led_o
);

  localparam logic [31:0] ADDR_VAL    = 32'h00;
  localparam logic [31:0] ADDR_MODE   = 32'h04;
  localparam logic [31:0] ADDR_PERIOD = 32'h08;
  localparam logic [31:0] ADDR_DUTY   = 32'h0C;
  localparam logic [31:0] ADDR_STATUS = 32'h10;
  localparam logic [31:0] ADDR_RESET  = 32'h24;

  logic wr_en, rd_en, soft_rst, clear;
  logic pwm_on;

  logic [LED_W-1:0] led_val_reg, led_val_next;
  logic [LED_W-1:0] led_mode_reg, led_mode_next;
  logic [31:0]      blink_period_reg, blink_period_next;
  logic [31:0]      blink_cnt_reg, blink_cnt_next;
  logic             phase_reg, phase_next;
  logic [31:0]      read_data_reg, read_data_next;
  logic [LED_W-1:0] led_reg, led_next;

  assign wr_en    = req_i & write_enable_i;
  assign rd_en    = req_i & ~write_enable_i;
  assign soft_rst = wr_en && (addr_i == ADDR_RESET) && write_data_i[0];
  assign clear    = !rst_ni || soft_rst;

`ifdef LED_SB_PWM_EN
  logic [PWM_W-1:0] pwm_duty_reg, pwm_duty_next;
  logic [PWM_W-1:0] pwm_cnt_reg;

  assign pwm_on = (pwm_cnt_reg < pwm_duty_reg) || (pwm_duty_reg == {PWM_W{1'b1}});

  always_comb begin
    pwm_duty_next = pwm_duty_reg;
    if (wr_en && (addr_i == ADDR_DUTY)) begin
      pwm_duty_next = write_data_i[PWM_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      pwm_duty_reg <= {PWM_W{1'b1}};
      pwm_cnt_reg  <= '0;
    end else begin
      pwm_duty_reg <= pwm_duty_next;
      pwm_cnt_reg  <= pwm_cnt_reg + 1'b1;
    end
  end
`else
  // Legal PWM_W is always >= 1, so brightness is permanently full.
  assign pwm_on = (PWM_W >= 1);
`endif

  always_comb begin
    led_val_next      = led_val_reg;
    led_mode_next     = led_mode_reg;
    blink_period_next = blink_period_reg;
    read_data_next    = read_data_reg;

    if (wr_en) begin
      case (addr_i)
        ADDR_VAL:    led_val_next  = write_data_i[LED_W-1:0];
        ADDR_MODE:   led_mode_next = write_data_i[LED_W-1:0];
        ADDR_PERIOD: blink_period_next = (write_data_i == 32'd0) ? 32'd1 : write_data_i;
        default:     ;
      endcase
    end

    if (rd_en) begin
      case (addr_i)
        ADDR_VAL:    read_data_next = 32'(led_val_reg);
        ADDR_MODE:   read_data_next = 32'(led_mode_reg);
        ADDR_PERIOD: read_data_next = blink_period_reg;
`ifdef LED_SB_PWM_EN
        ADDR_DUTY:   read_data_next = 32'(pwm_duty_reg);
`endif
        ADDR_STATUS: read_data_next = {31'd0, phase_reg};
        default:     read_data_next = 32'd0;
      endcase
    end
  end

  // A period write restarts the half-period so a shorter period never skips its wrap.
  always_comb begin
    blink_cnt_next = blink_cnt_reg + 32'd1;
    phase_next     = phase_reg;
    if (wr_en && (addr_i == ADDR_PERIOD)) begin
      blink_cnt_next = 32'd0;
      phase_next     = 1'b1;
    end else if (blink_cnt_reg >= blink_period_reg - 32'd1) begin
      blink_cnt_next = 32'd0;
      phase_next     = ~phase_reg;
    end
  end

  for (genvar gi = 0; gi < LED_W; gi++) begin : g_led
    assign led_next[gi] = led_val_reg[gi] & (~led_mode_reg[gi] | phase_reg) & pwm_on;
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      led_val_reg      <= '0;
      led_mode_reg     <= '0;
      blink_period_reg <= BLINK_DIV;
      blink_cnt_reg    <= 32'd0;
      phase_reg        <= 1'b1;
      read_data_reg    <= 32'd0;
      led_reg          <= '0;
    end else begin
      led_val_reg      <= led_val_next;
      led_mode_reg     <= led_mode_next;
      blink_period_reg <= blink_period_next;
      blink_cnt_reg    <= blink_cnt_next;
      phase_reg        <= phase_next;
      read_data_reg    <= read_data_next;
      led_reg          <= led_next;
    end
  end

  assign read_data_o = read_data_reg;
  assign led_o       = led_reg;

endmodule

// File: tb/tb_led_sb_ctrl_gen.sv
// Bench for led_sb_ctrl_gen: directed scenarios followed by random bus traffic,
// every cycle compared against a time-based reference model.
module tb_led_sb_ctrl_gen;

  localparam int unsigned LED_W     = 16;
  localparam int unsigned BLINK_DIV = 5;
  localparam int unsigned PWM_W     = 8;
  localparam int unsigned PWM_MAX   = (1 << PWM_W) - 1;
`ifdef LED_SB_PWM_EN
  localparam bit PWM_EN = 1'b1;
`else
  localparam bit PWM_EN = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             req_i = 1'b0;
  logic             write_enable_i = 1'b0;
  logic [31:0]      addr_i = '0;
  logic [31:0]      write_data_i = '0;
  logic [31:0]      read_data_o;
  logic [LED_W-1:0] led_o;

  always #5 clk_i = ~clk_i;

  led_sb_ctrl_gen #(.LED_W(LED_W), .BLINK_DIV(BLINK_DIV), .PWM_W(PWM_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .write_enable_i(write_enable_i),
    .addr_i(addr_i), .write_data_i(write_data_i), .read_data_o(read_data_o), .led_o(led_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: blink phase and PWM count derived from elapsed cycles.
  logic [LED_W-1:0] m_val, m_mode, m_led;
  int unsigned      m_period, m_duty, t_blink, t_pwm;
  logic [31:0]      m_rd;

  function automatic bit model_phase();
    return ((t_blink / m_period) % 2) == 0;
  endfunction

  function automatic bit model_pwm_on();
    if (!PWM_EN) return 1'b1;
    return (m_duty == PWM_MAX) || ((t_pwm % (PWM_MAX + 1)) < m_duty);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a)
      32'h00:  return 32'(m_val);
      32'h04:  return 32'(m_mode);
      32'h08:  return m_period;
      32'h0C:  return PWM_EN ? m_duty : 32'd0;
      32'h10:  return {31'd0, model_phase()};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_val = '0; m_mode = '0; m_led = '0; m_rd = '0;
    m_period = BLINK_DIV; m_duty = PWM_MAX; t_blink = 0; t_pwm = 0;
  endtask

  task automatic model_edge(input logic rst, req, we, input logic [31:0] a, wd);
    logic [LED_W-1:0] ph_mask, pwm_mask;
    if (!rst || (req && we && a == 32'h24 && wd[0])) begin
      model_reset();
      return;
    end
    ph_mask  = model_phase()  ? '1 : '0;
    pwm_mask = model_pwm_on() ? '1 : '0;
    m_led = m_val & (~m_mode | ph_mask) & pwm_mask;
    if (req && !we) m_rd = model_read(a);
    t_blink++;
    t_pwm++;
    if (req && we) begin
      case (a)
        32'h00: m_val  = wd[LED_W-1:0];
        32'h04: m_mode = wd[LED_W-1:0];
        32'h08: begin m_period = (wd == 0) ? 1 : wd; t_blink = 0; end
        32'h0C: if (PWM_EN) m_duty = wd[PWM_W-1:0];
        default: ;
      endcase
    end
  endtask

  // One clock of stimulus, then compare both outputs at the following negedge.
  task automatic cycle(input logic rst, req, we, input logic [31:0] a, wd);
    rst_ni = rst; req_i = req; write_enable_i = we; addr_i = a; write_data_i = wd;
    if (req) $display("[%0t] %s addr=0x%02h data=0x%08h rst_n=%0b", $time, we ? "WR" : "RD", a, wd, rst);
    @(posedge clk_i);
    model_edge(rst, req, we, a, wd);
    #1;
    rst_ni = 1'b1; req_i = 1'b0; write_enable_i = 1'b0;
    @(negedge clk_i);
    check_eq("led_o", 32'(led_o), 32'(m_led));
    check_eq("read_data_o", read_data_o, m_rd);
  endtask

  task automatic wr(input logic [31:0] a, wd); cycle(1'b1, 1'b1, 1'b1, a, wd); endtask
  task automatic rd(input logic [31:0] a);      cycle(1'b1, 1'b1, 1'b0, a, 32'd0); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic count_led0(input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      idle(1);
      ones += int'(led_o[0]);
    end
  endtask

  initial begin
    int ones;
    logic [31:0] addrs [8];
    addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h24, 32'h20, 32'h02};
    model_reset();
    @(negedge clk_i);

    // Reset and reset values
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_eq("reset_led", 32'(led_o), 32'd0);
    rd(32'h00); check_eq("reset_val", read_data_o, 32'd0);
    rd(32'h04); check_eq("reset_mode", read_data_o, 32'd0);
    rd(32'h08); check_eq("reset_period", read_data_o, BLINK_DIV);
    rd(32'h10); check_eq("reset_status", read_data_o, 32'd1);

    // Static LEDs
    wr(32'h00, 32'h0000A5F3);
    idle(1);
    check_eq("static_led", 32'(led_o), 32'h0000A5F3);
    rd(32'h00); check_eq("static_rb", read_data_o, 32'h0000A5F3);
    wr(32'h00, 32'hFFFF1234);
    rd(32'h00); check_eq("static_trunc", read_data_o, 32'h00001234);

    // Per-LED blink, then the period=0 corner
    wr(32'h08, 32'd4);
    wr(32'h00, 32'h000000FF);
    wr(32'h04, 32'h0000000F);
    idle(40);
    wr(32'h08, 32'd0);
    rd(32'h08); check_eq("period_zero", read_data_o, 32'd1);
    idle(12);

    // Soft reset and unmapped accesses
    wr(32'h24, 32'd1);
    idle(1);
    check_eq("soft_rst_led", 32'(led_o), 32'd0);
    rd(32'h08); check_eq("soft_rst_period", read_data_o, BLINK_DIV);
    wr(32'h00, 32'h00000003);
    wr(32'h20, 32'hFFFFFFFF);
    wr(32'h02, 32'hFFFFFFFF);
    rd(32'h20); check_eq("unmapped_20", read_data_o, 32'd0);
    rd(32'h02); check_eq("unmapped_02", read_data_o, 32'd0);
    rd(32'h00); check_eq("unmapped_nochg", read_data_o, 32'd3);

    // PWM brightness
    wr(32'h00, 32'h00000001);
    wr(32'h0C, 32'd64);
    idle(2);
    count_led0(256, ones); check_eq("pwm_duty64", ones, PWM_EN ? 32'd64 : 32'd256);
    wr(32'h0C, 32'd0);
    idle(2);
    count_led0(256, ones); check_eq("pwm_duty0", ones, PWM_EN ? 32'd0 : 32'd256);
    wr(32'h0C, 32'd255);
    idle(2);
    count_led0(256, ones); check_eq("pwm_duty255", ones, 32'd256);
    rd(32'h0C); check_eq("duty_rb", read_data_o, PWM_EN ? 32'd255 : 32'd0);

    // Random traffic, including resets mid-blink and mid-PWM
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, wd;
      logic        rst, req;
      a   = addrs[$urandom_range(0, 7)];
      wd  = $urandom();
      if (a == 32'h08) wd = $urandom_range(0, 6);
      if (a == 32'h24) wd = ($urandom_range(0, 7) == 0) ? 32'd1 : 32'd0;
      rst = ($urandom_range(0, 99) != 0);
      req = ($urandom_range(0, 2) == 0);
      cycle(rst, req, 1'($urandom_range(0, 1)), a, wd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
